// File: rtl/drp_pkg.sv
// Shared definitions for the DRP/XADC responder: register addresses,
// conversion channel order and sequencer state encoding.
package drp_pkg;

    localparam int unsigned NUM_CH = 5;

    localparam logic [6:0] ADDR_VPVN   = 7'h03;
    localparam logic [6:0] ADDR_VAUX2  = 7'h12;
    localparam logic [6:0] ADDR_VAUX3  = 7'h13;
    localparam logic [6:0] ADDR_VAUX10 = 7'h1A;
    localparam logic [6:0] ADDR_VAUX11 = 7'h1B;
    localparam logic [6:0] ADDR_CFG0   = 7'h40;
    localparam logic [6:0] ADDR_CFG1   = 7'h41;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_CONV,
        SEQ_EOC
    } seq_state_e;

    // Index into the conversion order; index i is enabled by CFG1[i].
    typedef logic [2:0] ch_idx_t;

    // Channel-order table: 0x12, 0x13, 0x1A, 0x1B, 0x03.
    function automatic logic [4:0] ch_addr(input ch_idx_t idx);
        logic [4:0] a;
        case (idx)
            3'd0:    a = ADDR_VAUX2[4:0];
            3'd1:    a = ADDR_VAUX3[4:0];
            3'd2:    a = ADDR_VAUX10[4:0];
            3'd3:    a = ADDR_VAUX11[4:0];
            3'd4:    a = ADDR_VPVN[4:0];
            default: a = '0;
        endcase
        return a;
    endfunction

    // Next enabled channel after cur, wrapping; returns cur if nothing else is enabled.
    function automatic ch_idx_t next_enabled(input ch_idx_t cur, input logic [4:0] en);
        ch_idx_t      res;
        logic         found;
        int unsigned  k;
        res   = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            k = (32'(cur) + i) % NUM_CH;
            if (!found && en[k]) begin
                res   = ch_idx_t'(k);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // First enabled channel in order (search starts just after the last slot).
    function automatic ch_idx_t first_enabled(input logic [4:0] en);
        return next_enabled(ch_idx_t'(NUM_CH - 1), en);
    endfunction

endpackage

// File: rtl/adc_conv_sequencer.sv
// Conversion sequencer: fixed-length slots, one eoc pulse per slot,
// round-robin over the enabled channels.
module adc_conv_sequencer
    import drp_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 26
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [4:0]    en_i,
    output logic          eoc_o,
    output logic [4:0]    channel_o,
    output logic [4:0]    sample_ch_o,
    output logic          stat_we_o,
    output ch_idx_t       stat_idx_o
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_idx_t          idx_q, idx_d;
    logic [4:0]       chan_q, chan_d;

    // Next-state: CONV lasts CONV_CYCLES-1 cycles, EOC one cycle, then advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chan_d  = chan_q;
        case (state_q)
            SEQ_IDLE: begin
                cnt_d = '0;
                if (en_i != '0) begin
                    state_d = SEQ_CONV;
                    idx_d   = first_enabled(en_i);
                end
            end
            SEQ_CONV: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 2)) begin
                    state_d = SEQ_EOC;
                    cnt_d   = '0;
                    chan_d  = ch_addr(idx_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ_EOC: begin
                if (en_i == '0) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_CONV;
                    idx_d   = next_enabled(idx_q, en_i);
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset starts at index 0, the first channel enabled by the CFG1 reset value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEQ_CONV;
            cnt_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chan_q  <= chan_d;
        end
    end

    assign eoc_o       = (state_q == SEQ_EOC);
    assign stat_we_o   = (state_q == SEQ_EOC);
    assign stat_idx_o  = idx_q;
    assign channel_o   = chan_q;
    assign sample_ch_o = ch_addr(idx_q);

endmodule

// File: rtl/drp_adc_responder.sv
// XADC DRP slave model: handshake with fixed read latency, status/config
// register file and the conversion sequencer that fills the status registers.
module drp_adc_responder
    import drp_pkg::*;
#(
    parameter int unsigned CONV_CYCLES  = 26,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              den_in,
    input  logic              dwe_in,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic [DATA_W-1:0] di_in,
    output logic [DATA_W-1:0] do_out,
    output logic              drdy_out,
    output logic              busy_out,
    output logic              eoc_out,
    output logic [4:0]        channel_out,
    output logic [4:0]        sample_ch,
    input  logic [DATA_W-1:0] sample_in,
    output logic              prot_err
);

    logic              busy_q, busy_d;
    logic [3:0]        lat_q, lat_d;
    logic              drdy_q, drdy_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              prot_q;
    logic [DATA_W-1:0] stat_q [NUM_CH];
    logic [DATA_W-1:0] cfg0_q, cfg1_q;
    logic [DATA_W-1:0] rd_val;
    logic              accept;
    logic              stat_we;
    ch_idx_t           stat_idx;

    assign accept = den_in & ~busy_q;

    adc_conv_sequencer #(
        .CONV_CYCLES (CONV_CYCLES)
    ) u_seq (
        .clk_i       (CLK100MHZ),
        .rst_ni      (CPU_RESETN),
        .en_i        (cfg1_q[4:0]),
        .eoc_o       (eoc_out),
        .channel_o   (channel_out),
        .sample_ch_o (sample_ch),
        .stat_we_o   (stat_we),
        .stat_idx_o  (stat_idx)
    );

    // Read mux over the register map; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        case (daddr_in)
            ADDR_VAUX2:  rd_val = stat_q[0];
            ADDR_VAUX3:  rd_val = stat_q[1];
            ADDR_VAUX10: rd_val = stat_q[2];
            ADDR_VAUX11: rd_val = stat_q[3];
            ADDR_VPVN:   rd_val = stat_q[4];
            ADDR_CFG0:   rd_val = cfg0_q;
            ADDR_CFG1:   rd_val = cfg1_q;
            default:     rd_val = '0;
        endcase
    end

    // Handshake: snapshot on accept, count to READ_LATENCY, pulse drdy, drop busy after drdy.
    always_comb begin
        busy_d  = busy_q;
        lat_d   = lat_q;
        drdy_d  = 1'b0;
        we_d    = we_q;
        rdata_d = rdata_q;
        do_d    = do_q;
        if (busy_q) begin
            if (drdy_q) begin
                busy_d = 1'b0;
            end else if (lat_q == 4'(READ_LATENCY)) begin
                drdy_d = 1'b1;
                if (!we_q) begin
                    do_d = rdata_q;
                end
            end else begin
                lat_d = lat_q + 4'd1;
            end
        end else if (den_in) begin
            busy_d  = 1'b1;
            lat_d   = 4'd1;
            we_d    = dwe_in;
            rdata_d = rd_val;
        end
    end

    // Handshake registers and sticky protocol-error flag.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            busy_q  <= 1'b0;
            lat_q   <= '0;
            drdy_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            do_q    <= '0;
            prot_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            lat_q   <= lat_d;
            drdy_q  <= drdy_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            do_q    <= do_d;
            prot_q  <= prot_q | (den_in & busy_q);
        end
    end

    // Register file: CFG written by accepted DRP writes, status written by the sequencer.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cfg0_q <= '0;
            cfg1_q <= DATA_W'(16'h000F);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            if (accept && dwe_in && daddr_in == ADDR_CFG0) begin
                cfg0_q <= di_in;
            end
            if (accept && dwe_in && daddr_in == ADDR_CFG1) begin
                cfg1_q <= di_in;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (stat_we && stat_idx == ch_idx_t'(i)) begin
                    stat_q[i] <= sample_in;
                end
            end
        end
    end

    assign busy_out = busy_q;
    assign drdy_out = drdy_q;
    assign do_out   = do_q;
    assign prot_err = prot_q;

endmodule
